// File: rtl/mpc_div_seq_29s_8s_21.sv
// Sequential signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per clock-enabled cycle, followed by a sign-fix step.
// Optional feature macro: MPC_DIV_SAT_EN -- when defined, an overflowing
// quotient saturates to the signed extremes instead of wrapping.
module mpc_div_seq_29s_8s_21 #(
    parameter int din0_WIDTH = 29,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 21
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic                  div_zero
);

    localparam int W0 = din0_WIDTH;
    localparam int W1 = din1_WIDTH;
    localparam int WD = dout_WIDTH;
    localparam int CW = $clog2(W0);

    localparam logic [W0-1:0] QLIM_POS = W0'((64'd1 << (WD - 1)) - 64'd1);
    localparam logic [W0-1:0] QLIM_NEG = W0'(64'd1 << (WD - 1));
    localparam logic [WD-1:0] DMAX     = {1'b0, {(WD - 1){1'b1}}};
    localparam logic [WD-1:0] DMIN     = {1'b1, {(WD - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [W0-1:0]  dvd_sh;
    logic [W0-1:0]  quo;
    logic [W1:0]    part;
    logic [W1:0]    dmag;
    logic           neg_q;
    logic           neg_r;
    logic           by_zero;

    logic [W0:0]    ext0;
    logic [W0:0]    mag0;
    logic [W1:0]    ext1;
    logic [W1:0]    mag1;
    logic [W1+1:0]  shifted;
    logic [W1+1:0]  diff;
    logic           qbit;
    logic [W1:0]    part_next;

    logic [WD-1:0]  qlow;
    logic [WD-1:0]  q_wrap;
    logic [WD-1:0]  dout_c;
    logic [W1-1:0]  rem_mag;
    logic [W1-1:0]  rem_c;
    logic           ovf_c;

    // Operand magnitudes are formed one bit wider than the operands so the
    // most-negative values negate without wrapping.
    always_comb begin
        ext0 = {din0[W0-1], din0};
        mag0 = ext0[W0] ? (~ext0 + 1'b1) : ext0;
        ext1 = {din1[W1-1], din1};
        mag1 = ext1[W1] ? (~ext1 + 1'b1) : ext1;
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only when it does not borrow.
    always_comb begin
        shifted   = {part, dvd_sh[W0-1]};
        diff      = shifted - {1'b0, dmag};
        qbit      = ~diff[W1+1];
        part_next = qbit ? diff[W1:0] : shifted[W1:0];
    end

    // Sign application, overflow detection and divide-by-zero substitution
    // for the value loaded into the outputs when DONE is entered.
    always_comb begin
        qlow    = quo[WD-1:0];
        q_wrap  = neg_q ? (~qlow + 1'b1) : qlow;
        ovf_c   = neg_q ? (quo > QLIM_NEG) : (quo > QLIM_POS);
        rem_mag = part[W1-1:0];
        rem_c   = neg_r ? (~rem_mag + 1'b1) : rem_mag;
        dout_c  = q_wrap;
        if (by_zero) begin
            dout_c = neg_r ? DMIN : DMAX;
            rem_c  = '0;
            ovf_c  = 1'b1;
        end else if (ovf_c) begin
`ifdef MPC_DIV_SAT_EN
            dout_c = neg_q ? DMIN : DMAX;
`else
            dout_c = q_wrap;
`endif
        end
    end

    // Control FSM and datapath registers; nothing moves while ce is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            dvd_sh   <= '0;
            quo      <= '0;
            part     <= '0;
            dmag     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            by_zero  <= 1'b0;
            dout     <= '0;
            rem      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            div_zero <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy    <= 1'b1;
                        neg_q   <= din0[W0-1] ^ din1[W1-1];
                        neg_r   <= din0[W0-1];
                        dmag    <= mag1;
                        dvd_sh  <= mag0[W0-1:0];
                        part    <= {{W1{1'b0}}, mag0[W0]};
                        quo     <= '0;
                        cnt     <= '0;
                        by_zero <= (din1 == '0);
                        state   <= (din1 == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    part   <= part_next;
                    dvd_sh <= {dvd_sh[W0-2:0], 1'b0};
                    quo    <= {quo[W0-2:0], qbit};
                    if (cnt == CW'(W0 - 1)) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    dout     <= dout_c;
                    rem      <= rem_c;
                    ovf      <= ovf_c;
                    div_zero <= by_zero;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpc_div_seq_29s_8s_21.sv
// Directed self-checking bench for mpc_div_seq_29s_8s_21 with hand-computed
// quotients, remainders, flags and done latencies.
module tb_mpc_div_seq_29s_8s_21;

    logic               clk;
    logic               reset;
    logic               ce;
    logic               start;
    logic [28:0]        din0;
    logic [7:0]         din1;
    logic [20:0]        dout;
    logic [7:0]         rem;
    logic               busy;
    logic               done;
    logic               ovf;
    logic               div_zero;

    int checks;
    int errors;
    int edges;
    int done_seen;

    mpc_div_seq_29s_8s_21 dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .start    (start),
        .din0     (din0),
        .din1     (din1),
        .dout     (dout),
        .rem      (rem),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .div_zero (div_zero)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present operands with start for one cycle; the following rising edge
    // is the accepting edge.
    task automatic applyStimulus(input int a, input int b);
        @(negedge clk);
        din0  = 29'(a);
        din1  = 8'(b);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count rising edges until done is seen, bounded so a stuck design
    // still reaches the summary.
    task automatic waitDone(output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkResult(input string tag, input int exp_lat, input int exp_q,
                               input int exp_r, input int exp_ovf, input int exp_dz);
        checkOutput({tag, " latency"}, edges, exp_lat);
        checkOutput({tag, " dout"}, $signed(dout), exp_q);
        checkOutput({tag, " rem"}, $signed(rem), exp_r);
        checkOutput({tag, " ovf"}, ovf, exp_ovf);
        checkOutput({tag, " div_zero"}, div_zero, exp_dz);
    endtask

    // Linear sequence of directed division scenarios.
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        ce     = 1'b1;
        start  = 1'b0;
        din0   = '0;
        din1   = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset dout", $signed(dout), 0);
        checkOutput("reset rem", $signed(rem), 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset ovf", ovf, 0);
        checkOutput("reset div_zero", div_zero, 0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] basic positive division");
        applyStimulus(1000, 7);
        checkOutput("1000/7 busy after accept", busy, 1);
        waitDone(edges);
        checkResult("1000/7", 31, 142, 6, 0, 0);
        checkOutput("1000/7 busy at done", busy, 0);
        @(posedge clk);
        #1;
        checkOutput("1000/7 done pulse width", done, 0);

        $display("[TB] sign combinations");
        applyStimulus(-1000, 7);
        waitDone(edges);
        checkResult("-1000/7", 31, -142, -6, 0, 0);
        applyStimulus(1000, -7);
        waitDone(edges);
        checkResult("1000/-7", 31, -142, 6, 0, 0);
        applyStimulus(-300, -128);
        waitDone(edges);
        checkResult("-300/-128", 31, 2, -44, 0, 0);

        $display("[TB] quotient range boundaries");
        applyStimulus(-1048576, 1);
        waitDone(edges);
        checkResult("-2^20/1", 31, -1048576, 0, 0, 0);
        applyStimulus(1048576, 1);
        waitDone(edges);
`ifdef MPC_DIV_SAT_EN
        checkResult("2^20/1", 31, 1048575, 0, 1, 0);
`else
        checkResult("2^20/1", 31, -1048576, 0, 1, 0);
`endif
        applyStimulus(268435455, 1);
        waitDone(edges);
`ifdef MPC_DIV_SAT_EN
        checkResult("maxpos/1", 31, 1048575, 0, 1, 0);
`else
        checkResult("maxpos/1", 31, -1, 0, 1, 0);
`endif
        applyStimulus(-268435456, 127);
        waitDone(edges);
`ifdef MPC_DIV_SAT_EN
        checkResult("minneg/127", 31, -1048576, -1, 1, 0);
`else
        checkResult("minneg/127", 31, -16513, -1, 1, 0);
`endif

        $display("[TB] divide by zero");
        applyStimulus(-5, 0);
        waitDone(edges);
        checkResult("-5/0", 2, -1048576, 0, 1, 1);
        applyStimulus(5, 0);
        waitDone(edges);
        checkResult("5/0", 2, 1048575, 0, 1, 1);
        applyStimulus(-300, -128);
        waitDone(edges);
        checkResult("-300/-128 after zero", 31, 2, -44, 0, 0);

        $display("[TB] clock enable stall and start while busy");
        applyStimulus(1000, 7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        din0  = 29'(50);
        din1  = 8'(5);
        start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ce    = 1'b0;
        checkOutput("stall busy", busy, 1);
        checkOutput("stall dout holds", $signed(dout), 2);
        repeat (10) @(posedge clk);
        @(negedge clk);
        checkOutput("stall frozen busy", busy, 1);
        ce = 1'b1;
        waitDone(edges);
        checkResult("stalled 1000/7", 26, 142, 6, 0, 0);

        $display("[TB] reset mid-calculation");
        applyStimulus(1000, 7);
        repeat (14) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("abort dout", $signed(dout), 0);
        checkOutput("abort rem", $signed(rem), 0);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort done", done, 0);
        checkOutput("abort ovf", ovf, 0);
        checkOutput("abort div_zero", div_zero, 0);
        @(negedge clk);
        reset = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        checkOutput("abort no done", done_seen, 0);
        applyStimulus(84, -4);
        waitDone(edges);
        checkResult("84/-4 after abort", 31, -21, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mpc_div_seq_29s_8s_21.md
MPC_DIV_SEQ_29S_8S_21 -- requirements
Module: mpc_div_seq_29s_8s_21

Interface
REQ-001 SHALL have parameter din0_WIDTH, default 29, dividend width.
REQ-002 SHALL have parameter din1_WIDTH, default 8, divisor width.
REQ-003 SHALL have parameter dout_WIDTH, default 21, quotient width.
REQ-004 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ce, input, 1, clock enable; low freezes all state and outputs.
REQ-007 SHALL have port start, input, 1, request pulse sampled in IDLE.
REQ-008 SHALL have port din0, input, din0_WIDTH, signed two's-complement dividend.
REQ-009 SHALL have port din1, input, din1_WIDTH, signed two's-complement divisor.
REQ-010 SHALL have port dout, output, dout_WIDTH, signed quotient.
REQ-011 SHALL have port rem, output, din1_WIDTH, signed remainder.
REQ-012 SHALL have port busy, output, 1, high while a division is in progress.
REQ-013 SHALL have port done, output, 1, one-ce-cycle result-valid pulse.
REQ-014 SHALL have port ovf, output, 1, quotient exceeded dout range.
REQ-015 SHALL have port div_zero, output, 1, divisor was zero.

Function
REQ-016 SHALL implement states IDLE, CALC, FIX, DONE, advancing only on edges with ce=1.
REQ-017 IDLE: start=1 SHALL latch din0/din1, record operand signs and magnitudes, and go to CALC, or go to FIX if din1=0.
REQ-018 CALC SHALL run restoring shift-subtract on magnitudes, one quotient bit per ce cycle, for exactly din0_WIDTH cycles, then go to FIX.
REQ-019 FIX SHALL apply signs (quotient negated if signs differ, remainder takes dividend sign), then go to DONE.
REQ-020 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-021 With no divide by zero, done SHALL rise din0_WIDTH+2 ce-enabled edges after the accepting edge (31 at defaults).
REQ-022 Division SHALL truncate toward zero, and |rem| SHALL be less than |din1|.
REQ-023 busy SHALL be high from the edge after acceptance through the DONE cycle inclusive.
REQ-024 start SHALL be ignored while busy=1, with no effect on the operation in progress.
REQ-025 dout, rem, ovf and div_zero SHALL update only at DONE entry and hold until the next DONE.
REQ-026 If the true quotient lies outside [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1], ovf SHALL be 1 for that result.
REQ-027 Divide by zero: div_zero=1, ovf=1, rem=0, and dout = +max if din0>=0, else -min; done SHALL follow 2 ce-enabled edges after acceptance.
REQ-028 The most-negative dividend (-2^28) SHALL be handled via a din0_WIDTH+1-bit magnitude, with no wrap.

Reset
REQ-029 reset=0 SHALL asynchronously force IDLE, with busy=0, done=0, ovf=0, div_zero=0, dout=0, rem=0.
REQ-030 Reset during CALC or FIX SHALL abort the operation with no done pulse; the first start after release SHALL behave normally.

Configuration
REQ-031 With macro MPC_DIV_SAT_EN defined, an overflowing quotient SHALL saturate to +max or -min by sign.
REQ-032 Without MPC_DIV_SAT_EN, an overflowing dout SHALL be the low dout_WIDTH bits of the true quotient, with ovf still reported.
REQ-033 Divide-by-zero behaviour (REQ-027) SHALL be identical with and without the macro.

Verification
REQ-034 din0=1000, din1=7, start -> done at edge 31; dout=142, rem=6, ovf=0.
REQ-035 din0=-1000, din1=7 -> dout=-142, rem=-6; din0=1000, din1=-7 -> dout=-142, rem=6.
REQ-036 din0=268435455, din1=1 -> ovf=1; dout=1048575 with MPC_DIV_SAT_EN, dout=-1 (0x1FFFFF) without.
REQ-037 din0=-5, din1=0 -> done at edge 2; div_zero=1, ovf=1, dout=-1048576, rem=0.
REQ-038 ce held low 10 cycles mid-CALC -> done delayed by exactly 10 cycles with the same result; second start while busy is ignored.
REQ-039 reset=0 at CALC cycle 15 -> all outputs 0, no done; next start 84/-4 -> dout=-21, rem=0.
